// File: rtl/mem_pkg.sv
// mem_pkg: shared tile types, default sizes and region offsets for the operand register file
package mem_pkg;
    localparam int WIDTH        = 16;
    localparam int NUM_INPUTS   = 4;
    localparam int NUM_REGS     = 16;
    localparam int TOTAL_INPUTS = 2 * NUM_INPUTS;
    localparam int N1_BASE      = 0;
    localparam int N2_BASE      = NUM_INPUTS;
    localparam int CFG_IDX      = 2 * NUM_INPUTS;
    typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/mem_region_wr.sv
// mem_region_wr: W x N word slice loaded whole on enable, cleared by async active-low reset
module mem_region_wr #(
    parameter int W = 16,
    parameter int N = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N-1:0][W-1:0] d,
    output logic [N-1:0][W-1:0] q
);
    // load the full region in one edge so a reader never sees a mixed vector
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/mem.sv
// mem: operand register file collecting two neighbour vectors and a config scalar for the vector FU
module mem
    import mem_pkg::*;
#(
    parameter  int width        = WIDTH,
    parameter  int num_regs     = NUM_REGS,
    parameter  int num_inputs   = NUM_INPUTS,
    localparam int total_inputs = 2 * num_inputs
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 on_off,
    input  logic                                 write_en1,
    output logic                                 write_rdy1,
    input  logic [num_inputs-1:0][width-1:0]     w_data_in1,
    input  logic                                 write_en2,
    output logic                                 write_rdy2,
    input  logic [num_inputs-1:0][width-1:0]     w_data_in2,
    input  logic                                 write_en3,
    output logic                                 write_rdy3,
    input  logic [width-1:0]                     w_data_in3,
    output logic                                 write_ack,
    output logic [total_inputs:0][width-1:0]     r_data_out,
    output logic                                 on_off_vector_fu
);
    if (num_regs < total_inputs + 1) begin : g_size_check
        $error("mem: num_regs must be at least 2*num_inputs+1");
    end

    logic                            rdy, acc1, acc2, acc3;
    logic [num_inputs-1:0][width-1:0] q1, q2;
    logic [0:0][width-1:0]           q3;

    assign rdy        = reset & ~on_off;
    assign write_rdy1 = rdy;
    assign write_rdy2 = rdy;
    assign write_rdy3 = rdy;
    assign acc1       = write_en1 & rdy;
    assign acc2       = write_en2 & rdy;
    assign acc3       = write_en3 & rdy;

    mem_region_wr #(.W(width), .N(num_inputs)) u_n1 (
        .clk(clk), .reset(reset), .en(acc1), .d(w_data_in1), .q(q1)
    );
    mem_region_wr #(.W(width), .N(num_inputs)) u_n2 (
        .clk(clk), .reset(reset), .en(acc2), .d(w_data_in2), .q(q2)
    );
    mem_region_wr #(.W(width), .N(1)) u_cfg (
        .clk(clk), .reset(reset), .en(acc3), .d(w_data_in3), .q(q3)
    );

    // regions are disjoint, so the operand bus is a plain concatenation in index order
    assign r_data_out = {q3, q2, q1};

    // ack any accepted write one cycle later; FU enable follows on_off by one edge
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            write_ack        <= 1'b0;
            on_off_vector_fu <= 1'b0;
        end else begin
            write_ack        <= acc1 | acc2 | acc3;
            on_off_vector_fu <= on_off;
        end
endmodule

// File: tb/tb_mem.sv
// tb_mem: randomized scoreboard bench for mem against an array-based reference model
module tb_mem;
    import mem_pkg::*;

    typedef logic [NUM_INPUTS-1:0][WIDTH-1:0] vec_t;
    typedef logic [TOTAL_INPUTS:0][WIDTH-1:0] bus_t;
    typedef struct packed {
        logic ack;
        logic fu;
        bus_t data;
    } exp_t;

    logic clk = 0;
    logic reset = 0;
    logic on_off = 0;
    logic write_en1 = 0, write_en2 = 0, write_en3 = 0;
    logic write_rdy1, write_rdy2, write_rdy3;
    vec_t w_data_in1 = '0, w_data_in2 = '0;
    word_t w_data_in3 = '0;
    logic write_ack, on_off_vector_fu;
    bus_t r_data_out;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    word_t model [TOTAL_INPUTS+1];

    mem dut (
        .clk(clk), .reset(reset), .on_off(on_off),
        .write_en1(write_en1), .write_rdy1(write_rdy1), .w_data_in1(w_data_in1),
        .write_en2(write_en2), .write_rdy2(write_rdy2), .w_data_in2(w_data_in2),
        .write_en3(write_en3), .write_rdy3(write_rdy3), .w_data_in3(w_data_in3),
        .write_ack(write_ack), .r_data_out(r_data_out), .on_off_vector_fu(on_off_vector_fu)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [255:0] got, logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    function automatic vec_t mk4(int a, int b, int c, int d);
        vec_t v;
        v[0] = word_t'(a); v[1] = word_t'(b); v[2] = word_t'(c); v[3] = word_t'(d);
        return v;
    endfunction

    function automatic bus_t model_bus();
        bus_t b;
        for (int i = 0; i <= TOTAL_INPUTS; i++) b[i] = model[i];
        return b;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i <= TOTAL_INPUTS; i++) model[i] = '0;
    endfunction

    task automatic step(input logic oo, input logic e1, input logic e2, input logic e3,
                        input vec_t a, input vec_t b, input word_t c);
        exp_t e;
        @(negedge clk);
        on_off = oo; write_en1 = e1; write_en2 = e2; write_en3 = e3;
        w_data_in1 = a; w_data_in2 = b; w_data_in3 = c;
        if (!oo) begin
            if (e1) for (int i = 0; i < NUM_INPUTS; i++) model[N1_BASE + i] = a[i];
            if (e2) for (int i = 0; i < NUM_INPUTS; i++) model[N2_BASE + i] = b[i];
            if (e3) model[CFG_IDX] = c;
        end
        e.ack = !oo && (e1 || e2 || e3);
        e.fu = oo;
        e.data = model_bus();
        sb.push_back(e);
        #1;
        chk("rdy", {write_rdy1, write_rdy2, write_rdy3}, {3{!oo}});
    endtask

    task automatic idle(input logic oo);
        step(oo, 0, 0, 0, w_data_in1, w_data_in2, w_data_in3);
    endtask

    // monitor: every edge that the driver scheduled must show the predicted ack, FU enable and bus
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("write_ack", write_ack, e.ack);
            chk("on_off_vector_fu", on_off_vector_fu, e.fu);
            chk("r_data_out", r_data_out, e.data);
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        model_clear();
        #12;
        chk("reset_bus", r_data_out, '0);
        chk("reset_rdy", {write_rdy1, write_rdy2, write_rdy3}, 3'b000);
        chk("reset_ack", write_ack, 1'b0);
        chk("reset_fu", on_off_vector_fu, 1'b0);
        @(negedge clk);
        reset = 1;
        #1;
        chk("rdy_after_reset", {write_rdy1, write_rdy2, write_rdy3}, 3'b111);
        chk("bus_after_reset", r_data_out, '0);

        step(0, 1, 0, 0, mk4(1, 2, 3, 4), mk4(10, 11, 12, 13), 16'd100);
        step(0, 0, 1, 0, mk4(1, 2, 3, 4), mk4(10, 11, 12, 13), 16'd100);
        step(0, 0, 0, 1, mk4(1, 2, 3, 4), mk4(10, 11, 12, 13), 16'd100);
        idle(1);
        idle(1);
        step(1, 1, 0, 0, mk4(7, 7, 7, 7), mk4(8, 8, 8, 8), 16'd9);
        step(1, 1, 1, 1, mk4(7, 7, 7, 7), mk4(8, 8, 8, 8), 16'd9);
        idle(0);
        step(0, 1, 1, 1, mk4(2, 3, 4, 5), mk4(20, 21, 22, 23), 16'd200);
        idle(0);
        for (int k = 0; k < 4; k++)
            step(0, 1, 0, 0, mk4(k, k + 1, k + 2, k + 3), w_data_in2, w_data_in3);
        step(0, 1, 0, 0, mk4(1, 1, 1, 1), w_data_in2, w_data_in3);
        step(0, 0, 1, 0, w_data_in1, mk4(2, 2, 2, 2), w_data_in3);
        step(0, 0, 0, 1, w_data_in1, w_data_in2, 16'd3);
        idle(0);

        for (int k = 0; k < 300; k++)
            step(($urandom_range(3) == 0), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                 vec_t'({$urandom, $urandom}), vec_t'({$urandom, $urandom}), word_t'($urandom));

        step(0, 1, 1, 1, mk4(5, 6, 7, 8), mk4(9, 10, 11, 12), 16'h1234);
        step(1, 0, 0, 0, w_data_in1, w_data_in2, w_data_in3);
        drain();
        step(1, 1, 1, 1, mk4(40, 41, 42, 43), mk4(50, 51, 52, 53), 16'h4321);
        drain();
        #3;
        reset = 0;
        #1;
        chk("async_bus", r_data_out, '0);
        chk("async_ack", write_ack, 1'b0);
        chk("async_fu", on_off_vector_fu, 1'b0);
        chk("async_rdy", {write_rdy1, write_rdy2, write_rdy3}, 3'b000);
        model_clear();
        @(negedge clk);
        reset = 1;
        idle(0);
        step(0, 0, 0, 1, w_data_in1, w_data_in2, 16'hbeef);
        idle(0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
